// File: rtl/z16_pkg.sv
// z16_pkg: shared fetch state encoding and datapath widths
package z16_pkg;
   localparam int Z16_INSTR_W = 16;
   localparam int Z16_ADDR_W  = 16;
   localparam logic [Z16_ADDR_W-1:0] Z16_PC_INC = 16'd2;
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, WAIT_DROP} fetch_state_e;
endpackage

// File: rtl/z16_fetch_fifo.sv
// z16_fetch_fifo: 2-entry in-order buffer of {instr, pc}, head always in e0_q
module z16_fetch_fifo
   import z16_pkg::*;
(
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_push,
   input  logic                               i_pop,
   input  logic                               i_flush,
   input  logic [Z16_INSTR_W+Z16_ADDR_W-1:0]  i_data,
   output logic [Z16_INSTR_W+Z16_ADDR_W-1:0]  o_data,
   output logic [1:0]                         o_count
);
   logic [Z16_INSTR_W+Z16_ADDR_W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0] cnt_q, cnt_d, after_pop;
   logic pop;

   always_comb begin
      pop       = i_pop & ~i_flush;
      after_pop = cnt_q - {1'b0, pop};
      e0_d      = pop ? ((i_push && cnt_q == 2'd1) ? i_data : e1_q)
                      : ((i_push && cnt_q == 2'd0) ? i_data : e0_q);
      e1_d      = (i_push && after_pop == 2'd1) ? i_data : e1_q;
      cnt_d     = i_flush ? 2'd0 : after_pop + {1'b0, i_push};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign o_data  = e0_q;
   assign o_count = cnt_q;
endmodule

// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit: single-outstanding instruction fetch FSM feeding a 2-entry decode buffer
module z16_fetch_unit
   import z16_pkg::*;
#(
   parameter logic [Z16_ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   output logic                   o_imem_req,
   output logic [Z16_ADDR_W-1:0]  o_imem_addr,
   input  logic                   i_imem_gnt,
   input  logic                   i_imem_rvalid,
   input  logic [Z16_INSTR_W-1:0] i_imem_rdata,
   input  logic                   i_redirect,
   input  logic [Z16_ADDR_W-1:0]  i_redirect_pc,
   output logic                   o_valid,
   output logic [Z16_INSTR_W-1:0] o_instr,
   output logic [Z16_ADDR_W-1:0]  o_pc,
   input  logic                   i_ready
);
   fetch_state_e                         state_q;
   logic [Z16_ADDR_W-1:0]                pc_q;
   logic [Z16_INSTR_W+Z16_ADDR_W-1:0]    head;
   logic [1:0]                           count, cnt_nxt;
   logic                                 gnt, push, pop, cnt_ok;

   assign gnt     = o_imem_req & i_imem_gnt;
   assign push    = (state_q == WAIT_RSP) & i_imem_rvalid & ~i_redirect;
   assign pop     = o_valid & i_ready;
   assign cnt_nxt = count + {1'b0, push} - {1'b0, pop};
   assign cnt_ok  = cnt_nxt < 2'd2;
   assign o_valid = count != 2'd0;
   assign {o_instr, o_pc} = head;

   z16_fetch_fifo u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_pop   (pop),
      .i_flush (i_redirect),
      .i_data  ({i_imem_rdata, o_imem_addr}),
      .o_data  (head),
      .o_count (count)
   );

   // request is decided one edge ahead so o_imem_req is purely registered
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC & 16'hFFFE;
         o_imem_req  <= 1'b0;
         o_imem_addr <= '0;
      end else begin
         if (i_redirect) pc_q <= i_redirect_pc & 16'hFFFE;
         else if (gnt) pc_q <= o_imem_addr + Z16_PC_INC;
         case (state_q)
            IDLE: if (!i_redirect && cnt_ok) begin
               state_q     <= WAIT_GNT;
               o_imem_req  <= 1'b1;
               o_imem_addr <= pc_q;
            end
            WAIT_GNT: if (i_redirect || gnt) begin
               o_imem_req <= 1'b0;
               state_q    <= gnt ? (i_redirect ? WAIT_DROP : WAIT_RSP) : IDLE;
            end
            WAIT_RSP: if (i_redirect) state_q <= i_imem_rvalid ? IDLE : WAIT_DROP;
            else if (i_imem_rvalid) begin
               state_q     <= cnt_ok ? WAIT_GNT : IDLE;
               o_imem_req  <= cnt_ok;
               o_imem_addr <= cnt_ok ? pc_q : o_imem_addr;
            end
            WAIT_DROP: if (i_imem_rvalid) state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_z16_fetch_unit.sv
// tb_z16_fetch_unit: memory model, pc/instr scoreboard, redirect vector table
module tb_z16_fetch_unit;
   logic        i_clk = 1'b0, i_rst_n = 1'b0;
   logic        o_imem_req, o_valid;
   logic [15:0] o_imem_addr, o_instr, o_pc;
   logic        i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0, i_redirect = 1'b0, i_ready = 1'b0;
   logic [15:0] i_imem_rdata = '0, i_redirect_pc = '0;

   typedef struct {
      logic [15:0] pc_in;
      int          hold;
      logic [15:0] exp0, exp1, exp2;
   } vec_t;
   vec_t vecs[5];

   int n_chk = 0, n_fail = 0, n_cons = 0, cyc = 0, hold = 0, lat = 1, rsp_cnt = 0;
   logic [15:0] rsp_addr = '0, prev_addr = '0;
   logic [15:0] exp_q[$], req_log[$];
   int gnt_cyc[$];
   bit sb_en = 1'b1, gnt_seen = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b0, prev_rst = 1'b0;

   z16_fetch_unit dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_valid       (o_valid),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .i_ready       (i_ready)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [15:0] mem(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hA55A;
   endfunction

   function automatic logic [15:0] log_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 16'hDEAD;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < gnt_cyc.size()) ? gnt_cyc[i] : -100;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic mem_step();
      if (!i_rst_n) begin
         rsp_cnt = 0;
         i_imem_gnt = 1'b0;
         i_imem_rvalid = 1'b0;
         return;
      end
      i_imem_rvalid = 1'b0;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata = mem(rsp_addr);
         end
      end
      i_imem_gnt = o_imem_req && hold == 0;
      if (o_imem_req && hold > 0) hold--;
      if (i_imem_gnt) begin
         chk("one_outstanding", rsp_cnt, 0);
         rsp_cnt = lat;
         rsp_addr = o_imem_addr;
      end
   endtask

   task automatic monitor();
      logic [15:0] e;
      if (sb_en && o_valid && i_ready) begin
         n_cons++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_extra: got o_pc %h, expected no instruction", o_pc);
         end else begin
            e = exp_q.pop_front();
            chk("o_pc", o_pc, e);
            chk("o_instr", o_instr, mem(e));
         end
      end
      if (o_imem_req && i_imem_gnt) begin
         req_log.push_back(o_imem_addr);
         gnt_cyc.push_back(cyc);
         gnt_seen = 1'b1;
      end
      if (prev_rst && prev_req && !prev_gnt && !prev_redir) begin
         chk("req_held", o_imem_req, 1);
         chk("addr_held", o_imem_addr, prev_addr);
      end
      if (o_imem_req) chk("addr_bit0", o_imem_addr[0], 0);
      prev_rst = i_rst_n;
      prev_req = o_imem_req;
      prev_gnt = i_imem_gnt;
      prev_redir = i_redirect;
      prev_addr = o_imem_addr;
   endtask

   task automatic tick();
      @(negedge i_clk);
      monitor();
      @(posedge i_clk);
      #1;
      cyc++;
      mem_step();
   endtask

   task automatic clear_sb();
      exp_q.delete();
      req_log.delete();
      gnt_cyc.delete();
      n_cons = 0;
   endtask

   task automatic wait_cons(input int n, input string name);
      int t = 0;
      while (n_cons < n && t < 100) begin
         tick();
         t++;
      end
      chk({name, "_consumed"}, n_cons, n);
   endtask

   task automatic chk_rst(input string name);
      chk({name, "_req"}, o_imem_req, 0);
      chk({name, "_addr"}, o_imem_addr, 0);
      chk({name, "_valid"}, o_valid, 0);
      chk({name, "_instr"}, o_instr, 0);
      chk({name, "_pc"}, o_pc, 0);
   endtask

   task automatic release_rst();
      clear_sb();
      i_rst_n = 1'b1;
      tick();
      chk("first_req", o_imem_req, 1);
      chk("first_addr", o_imem_addr, 16'h0000);
   endtask

   initial begin
      int t;
      vecs[0] = '{16'h0200, 0, 16'h0200, 16'h0202, 16'h0204};
      vecs[1] = '{16'hFFFC, 0, 16'hFFFC, 16'hFFFE, 16'h0000};
      vecs[2] = '{16'hFFFE, 5, 16'hFFFE, 16'h0000, 16'h0002};
      vecs[3] = '{16'h1235, 2, 16'h1234, 16'h1236, 16'h1238};
      vecs[4] = '{16'h8000, 1, 16'h8000, 16'h8002, 16'h8004};

      repeat (3) tick();
      chk_rst("rst");

      // streaming fetch with an always-ready decoder
      release_rst();
      i_ready = 1'b1;
      exp_q = '{16'h0000, 16'h0002, 16'h0004};
      wait_cons(3, "seq");
      chk("seq_addr0", log_at(0), 16'h0000);
      chk("seq_addr1", log_at(1), 16'h0002);
      chk("seq_addr2", log_at(2), 16'h0004);
      chk("seq_period1", cyc_at(1) - cyc_at(0), 2);
      chk("seq_period2", cyc_at(2) - cyc_at(1), 2);

      // reset while a response is outstanding
      i_ready = 1'b0;
      i_rst_n = 1'b0;
      tick();
      chk_rst("mid_rst");
      release_rst();

      // decoder stalled: buffer fills to two and requests stop
      repeat (9) tick();
      chk("stall_valid", o_valid, 1);
      chk("stall_pc", o_pc, 16'h0000);
      chk("stall_instr", o_instr, mem(16'h0000));
      chk("stall_req", o_imem_req, 0);
      chk("stall_grants", req_log.size(), 2);
      exp_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
      i_ready = 1'b1;
      wait_cons(4, "drain");
      chk("resume_addr", log_at(2), 16'h0004);

      // redirect while waiting for a slow response
      sb_en = 1'b0;
      lat = 3;
      tick();
      gnt_seen = 1'b0;
      t = 0;
      while (!gnt_seen && t < 50) begin
         tick();
         t++;
      end
      chk("drop_setup", gnt_seen, 1);
      chk("drop_no_rvalid", i_imem_rvalid, 0);
      i_ready = 1'b0;
      i_redirect = 1'b1;
      i_redirect_pc = 16'h0100;
      lat = 1;
      sb_en = 1'b1;
      clear_sb();
      exp_q = '{16'h0100, 16'h0102};
      tick();
      i_redirect = 1'b0;
      chk("drop_valid", o_valid, 0);
      chk("drop_req", o_imem_req, 0);
      i_ready = 1'b1;
      wait_cons(2, "drop");
      chk("drop_addr", log_at(0), 16'h0100);

      // redirect in the same cycle as the response
      sb_en = 1'b0;
      tick();
      t = 0;
      while (!i_imem_rvalid && t < 50) begin
         tick();
         t++;
      end
      chk("rv_setup", i_imem_rvalid, 1);
      i_ready = 1'b0;
      i_redirect = 1'b1;
      i_redirect_pc = 16'h0040;
      sb_en = 1'b1;
      clear_sb();
      exp_q = '{16'h0040, 16'h0042};
      tick();
      i_redirect = 1'b0;
      chk("rv_valid", o_valid, 0);
      chk("rv_req", o_imem_req, 0);
      i_ready = 1'b1;
      tick();
      chk("rv_req_next", o_imem_req, 1);
      chk("rv_addr_next", o_imem_addr, 16'h0040);
      wait_cons(2, "rv");
      chk("rv_addr", log_at(0), 16'h0040);

      // redirect targets, wrap-around and withheld grants
      for (int i = 0; i < 5; i++) begin
         i_ready = 1'b0;
         i_redirect = 1'b1;
         i_redirect_pc = vecs[i].pc_in;
         hold = vecs[i].hold;
         clear_sb();
         exp_q = '{vecs[i].exp0, vecs[i].exp1, vecs[i].exp2};
         tick();
         i_redirect = 1'b0;
         i_ready = 1'b1;
         wait_cons(3, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_first_addr", i), log_at(0), vecs[i].exp0);
      end
      i_ready = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
